// File: rtl/prng_burst_pkg.sv
// rtl/prng_burst_pkg.sv - shared types and constants for prng_burst_ctrl
// Contents: burst FSM state enum, FIFO word width ({last, sample}), default FIFO depth.
package prng_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RANGE,
    ST_SETTLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DRAIN
  } burst_state_t;

  // One FIFO word is {last, sample[31:0]}
  localparam int FIFO_W        = 33;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/prng_burst_fifo.sv
// rtl/prng_burst_fifo.sv - DEPTH x 33 synchronous FIFO with flush and registered read port
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   flush                 empties the FIFO (wins over a same-cycle write)
//   wr_en, wr_data        push (ignored when full)
//   rd_en                 pop the head when rd_valid is high
//   rd_data, rd_valid     registered head word and its valid flag
//   full, empty           occupancy flags from the pointers
module prng_burst_fifo
  import prng_burst_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [FIFO_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FIFO_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [FIFO_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       rd_ptr_nxt;
  logic              pop;
  logic              push;

  assign pop        = rd_en && rd_valid;
  assign push       = wr_en && !full;
  assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal)
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // The head register is evaluated against the pre-write pointer, so a word
  // written into an empty FIFO shows up on rd_valid one cycle later.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= (wr_ptr != rd_ptr_nxt);
      if (wr_ptr != rd_ptr_nxt) begin
        rd_data <= mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/prng_burst_ctrl.sv
// rtl/prng_burst_ctrl.sv - burst controller driving the xorshift32_rng strobes into an output stream
// Optional feature macro: PRNG_BURST_RAW_SEL_EN (adds cmd_raw_sel, selects raw samples)
// Ports:
//   clk, aresetn                      clock, asynchronous active-low reset
//   cmd_*                             burst command (count, optional seed/range load, abort)
//   cmd_ready                         high only in IDLE
//   prng_enable/update_seed/range     generator strobes, prng_new_* their data
//   prng_reset                        generator soft reset, pulses on abort
//   prng_random_*, prng_valid         generator sample and its valid flag
//   out_valid/ready/data/last         sample stream from the FIFO head
//   busy, done, aborted, err_novalid  status
module prng_burst_ctrl
  import prng_burst_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_seed_en,
  input  logic [31:0]      cmd_seed,
  input  logic             cmd_range_en,
  input  logic [31:0]      cmd_low,
  input  logic [31:0]      cmd_high,
`ifdef PRNG_BURST_RAW_SEL_EN
  input  logic             cmd_raw_sel,
`endif
  input  logic             cmd_abort,
  output logic             prng_enable,
  output logic             prng_update_seed,
  output logic             prng_update_range,
  output logic [31:0]      prng_new_seed,
  output logic [31:0]      prng_new_low,
  output logic [31:0]      prng_new_high,
  output logic             prng_reset,
  input  logic [31:0]      prng_random_raw,
  input  logic [31:0]      prng_random_in_range,
  input  logic             prng_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_novalid
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  burst_state_t      state;
  burst_state_t      state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       seed_q;
  logic [31:0]       low_q;
  logic [31:0]       high_q;
  logic              range_en_q;
  logic              err_q;
  logic              done_q;
  logic              abort;
  logic              accept;
  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [31:0]       sample;

  assign abort  = cmd_abort && (state != ST_IDLE);
  assign accept = cmd_valid && (state == ST_IDLE);

`ifdef PRNG_BURST_RAW_SEL_EN
  logic raw_sel_q;
  assign sample = raw_sel_q ? prng_random_raw : prng_random_in_range;
`else
  logic unused_raw;
  assign unused_raw = ^prng_random_raw;
  assign sample     = prng_random_in_range;
`endif

  assign fifo_wdata = {remaining == CNT_ONE, sample};

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_seed_en)       state_nxt = ST_SEED;
          else if (cmd_range_en) state_nxt = ST_RANGE;
          else                   state_nxt = ST_SETTLE;
        end
      end
      ST_SEED:    state_nxt = range_en_q ? ST_RANGE : ST_SETTLE;
      ST_RANGE:   state_nxt = ST_SETTLE;
      ST_SETTLE:  state_nxt = (remaining == '0) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE:   if (!fifo_full) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = (remaining == CNT_ONE) ? ST_DRAIN : ST_ISSUE;
      // DRAIN holds for the cycle done is high, so cmd_ready rises after done
      ST_DRAIN:   if (done_q) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Outputs decoded from state; strobes are suppressed in an abort cycle
  always_comb begin
    cmd_ready         = 1'b0;
    busy              = 1'b1;
    prng_update_seed  = 1'b0;
    prng_update_range = 1'b0;
    prng_enable       = 1'b0;
    fifo_wr           = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_SEED:    prng_update_seed  = !abort;
      ST_RANGE:   prng_update_range = !abort;
      ST_ISSUE:   prng_enable       = !fifo_full && !abort;
      ST_CAPTURE: fifo_wr           = !abort;
      default:    ;
    endcase
  end

  assign prng_reset    = abort;
  assign aborted       = abort;
  assign done          = done_q;
  assign err_novalid   = err_q;
  assign prng_new_seed = seed_q;
  assign prng_new_low  = low_q;
  assign prng_new_high = high_q;

  // Command registers, down-counter and status flags
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      remaining  <= '0;
      seed_q     <= '0;
      low_q      <= '0;
      high_q     <= '0;
      range_en_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef PRNG_BURST_RAW_SEL_EN
      raw_sel_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        remaining  <= cmd_count;
        seed_q     <= cmd_seed;
        low_q      <= cmd_low;
        high_q     <= cmd_high;
        range_en_q <= cmd_range_en;
        err_q      <= 1'b0;
`ifdef PRNG_BURST_RAW_SEL_EN
        raw_sel_q  <= cmd_raw_sel;
`endif
      end else if (state == ST_CAPTURE && !abort) begin
        if (remaining != '0) begin
          remaining <= remaining - CNT_ONE;
        end
        if (!prng_valid) begin
          err_q <= 1'b1;
        end
      end
      done_q <= (state == ST_DRAIN) && fifo_empty && !done_q && !abort;
    end
  end

  prng_burst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .aresetn  (aresetn),
    .flush    (abort),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_en    (out_ready),
    .rd_data  (fifo_rdata),
    .rd_valid (out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_data = fifo_rdata[31:0];
  assign out_last = out_valid && fifo_rdata[32];

endmodule

// File: tb/tb_prng_burst_ctrl.sv
// tb/tb_prng_burst_ctrl.sv - self-checking bench for prng_burst_ctrl with an xorshift32 generator model
module tb_prng_burst_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_seed_en = 1'b0;
  logic [31:0]      cmd_seed = '0;
  logic             cmd_range_en = 1'b0;
  logic [31:0]      cmd_low = '0;
  logic [31:0]      cmd_high = '0;
  logic             cmd_abort = 1'b0;
  logic             out_ready = 1'b0;
`ifdef PRNG_BURST_RAW_SEL_EN
  logic             cmd_raw_sel = 1'b0;
`endif
  logic             cmd_ready, prng_enable, prng_update_seed, prng_update_range, prng_reset;
  logic [31:0]      prng_new_seed, prng_new_low, prng_new_high;
  logic [31:0]      prng_random_raw, prng_random_in_range;
  logic             prng_valid;
  logic             out_valid, out_last, busy, done, aborted, err_novalid;
  logic [31:0]      out_data;

  prng_burst_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .aresetn              (aresetn),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_count            (cmd_count),
    .cmd_seed_en          (cmd_seed_en),
    .cmd_seed             (cmd_seed),
    .cmd_range_en         (cmd_range_en),
    .cmd_low              (cmd_low),
    .cmd_high             (cmd_high),
`ifdef PRNG_BURST_RAW_SEL_EN
    .cmd_raw_sel          (cmd_raw_sel),
`endif
    .cmd_abort            (cmd_abort),
    .prng_enable          (prng_enable),
    .prng_update_seed     (prng_update_seed),
    .prng_update_range    (prng_update_range),
    .prng_new_seed        (prng_new_seed),
    .prng_new_low         (prng_new_low),
    .prng_new_high        (prng_new_high),
    .prng_reset           (prng_reset),
    .prng_random_raw      (prng_random_raw),
    .prng_random_in_range (prng_random_in_range),
    .prng_valid           (prng_valid),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_last             (out_last),
    .busy                 (busy),
    .done                 (done),
    .aborted              (aborted),
    .err_novalid          (err_novalid)
  );

  // Generator model: reset seed 42, range [0,100), sample valid the cycle after enable
  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  function automatic logic [31:0] map_rng(input logic [31:0] r, input logic [31:0] lo, input logic [31:0] hi);
    return (hi > lo) ? lo + (r % (hi - lo)) : lo;
  endfunction

  logic [31:0] g_state = 32'd42, g_low = 32'd0, g_high = 32'd100;
  logic        g_valid = 1'b0;
  int          g_en_cnt = 0;
  int          drop_at = 0;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      g_state <= 32'd42; g_low <= 32'd0; g_high <= 32'd100; g_valid <= 1'b0;
    end else if (prng_reset) begin
      g_state <= 32'd42; g_low <= 32'd0; g_high <= 32'd100; g_valid <= 1'b0;
    end else begin
      if (prng_update_seed) g_state <= prng_new_seed;
      if (prng_update_range) begin
        g_low  <= prng_new_low;
        g_high <= prng_new_high;
      end
      if (prng_enable) begin
        g_state  <= xs(g_state);
        g_en_cnt <= g_en_cnt + 1;
      end
      g_valid <= prng_enable && (g_en_cnt + 1 != drop_at);
    end
  end

  assign prng_random_raw      = g_state;
  assign prng_random_in_range = map_rng(g_state, g_low, g_high);
  assign prng_valid           = g_valid;

  // Monitor: cumulative event counts and captured stream words, sampled on negedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          en_n = 0, rx_n = 0, done_n = 0, abort_n = 0, preset_n = 0;
  int          seed_n = 0, range_n = 0, seed_cyc = 0, range_cyc = 0;
  int          en_cyc [256];
  logic [32:0] rx_mem [256];

  always @(negedge clk) begin
    if (prng_enable) begin
      en_cyc[en_n % 256] <= cyc;
      en_n <= en_n + 1;
    end
    if (out_valid && out_ready) begin
      rx_mem[rx_n % 256] <= {out_last, out_data};
      rx_n <= rx_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (aborted) abort_n <= abort_n + 1;
    if (prng_reset) preset_n <= preset_n + 1;
    if (prng_update_seed) begin seed_n <= seed_n + 1; seed_cyc <= cyc; end
    if (prng_update_range) begin range_n <= range_n + 1; range_cyc <= cyc; end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          count;
    bit          seed_en;
    logic [31:0] seed;
    bit          range_en;
    logic [31:0] low;
    logic [31:0] high;
    int          lat;
    logic [31:0] lo_bnd;
    logic [31:0] hi_bnd;
    int          drop;
    bit          err;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] r_state = 32'd42, r_low = 32'd0, r_high = 32'd100;

  task automatic send(input int count, input bit seed_en, input logic [31:0] seed,
                      input bit range_en, input logic [31:0] low, input logic [31:0] high,
                      output int acc);
    int n;
    cmd_count    = count[CNT_W-1:0];
    cmd_seed_en  = seed_en;
    cmd_seed     = seed;
    cmd_range_en = range_en;
    cmd_low      = low;
    cmd_high     = high;
    cmd_valid    = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick; n++; end
    acc = cyc;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin tick; n++; end
    chk({tag, " done_seen"}, done, 1'b1);
    dcyc = cyc;
  endtask

  task automatic check_words(input string tag, input int r0, input int cnt,
                             input bit bnd, input logic [31:0] lo, input logic [31:0] hi);
    logic [32:0] w;
    logic [31:0] ex;
    for (int i = 0; i < cnt; i++) begin
      r_state = xs(r_state);
      ex = map_rng(r_state, r_low, r_high);
      if (i < rx_n - r0) begin
        w = rx_mem[(r0 + i) % 256];
        chk($sformatf("%s word%0d data", tag, i), w[31:0], ex);
        chk($sformatf("%s word%0d last", tag, i), w[32], (i == cnt - 1));
        if (bnd) chk($sformatf("%s word%0d bounds", tag, i), (w[31:0] >= lo) && (w[31:0] <= hi), 1'b1);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int e0, r0, d0, s0, g0, acc, dcyc, bad_sp;
    e0 = en_n; r0 = rx_n; d0 = done_n; s0 = seed_n; g0 = range_n;
    if (v.drop != 0) drop_at = e0 + v.drop;
    if (v.seed_en) r_state = v.seed;
    if (v.range_en) begin r_low = v.low; r_high = v.high; end
    out_ready = 1'b1;
    send(v.count, v.seed_en, v.seed, v.range_en, v.low, v.high, acc);
    wait_done(tag, dcyc);
    chk({tag, " err_novalid"}, err_novalid, v.err);
    chk({tag, " ready_low_at_done"}, cmd_ready, 1'b0);
    tick;
    chk({tag, " ready_after_done"}, cmd_ready, 1'b1);
    chk({tag, " enables"}, en_n - e0, v.count);
    chk({tag, " words"}, rx_n - r0, v.count);
    chk({tag, " done_pulses"}, done_n - d0, 1);
    chk({tag, " seed_pulses"}, seed_n - s0, v.seed_en);
    chk({tag, " range_pulses"}, range_n - g0, v.range_en);
    if (v.count == 0) begin
      chk({tag, " done_latency"}, dcyc - acc, 3);
    end else if (en_n - e0 >= v.count) begin
      chk({tag, " setup_latency"}, en_cyc[e0 % 256] - acc, v.lat);
      bad_sp = 0;
      for (int i = 1; i < v.count; i++)
        if (en_cyc[(e0 + i) % 256] - en_cyc[(e0 + i - 1) % 256] != 2) bad_sp++;
      chk({tag, " enable_spacing_errs"}, bad_sp, 0);
      if (v.seed_en) chk({tag, " seed_before_enable"}, seed_cyc < en_cyc[e0 % 256], 1'b1);
      if (v.range_en) chk({tag, " range_before_enable"}, range_cyc < en_cyc[e0 % 256], 1'b1);
      if (v.seed_en && v.range_en) chk({tag, " seed_before_range"}, seed_cyc < range_cyc, 1'b1);
    end
    check_words(tag, r0, v.count, 1'b1, v.lo_bnd, v.hi_bnd);
  endtask

  localparam logic [10:0] RST_FLAGS = 11'b100_0000_0000;

  task automatic check_reset_values(input string tag);
    chk({tag, " flags"}, {cmd_ready, busy, done, aborted, err_novalid, out_valid, out_last,
                          prng_enable, prng_update_seed, prng_update_range, prng_reset}, RST_FLAGS);
    chk({tag, " out_data"}, out_data, 32'd0);
    chk({tag, " new_cfg"}, {prng_new_seed, prng_new_low, prng_new_high} == 96'd0, 1'b1);
  endtask

  initial begin
    int e0, r0, d0, a0, p0, acc, dcyc, n;

    vt[0] = '{5,  1'b0, 32'd0,         1'b0, 32'd0,    32'd0,    2, 32'd0,    32'd99,   0, 1'b0};
    vt[1] = '{10, 1'b1, 32'hDEADBEEF,  1'b1, 32'd50,   32'd150,  4, 32'd50,   32'd149,  0, 1'b0};
    vt[2] = '{0,  1'b0, 32'd0,         1'b0, 32'd0,    32'd0,    2, 32'd50,   32'd149,  0, 1'b0};
    vt[3] = '{3,  1'b0, 32'd0,         1'b1, 32'd1000, 32'd1010, 3, 32'd1000, 32'd1009, 0, 1'b0};
    vt[4] = '{4,  1'b1, 32'h12345678,  1'b0, 32'd0,    32'd0,    3, 32'd1000, 32'd1009, 2, 1'b1};
    vt[5] = '{1,  1'b0, 32'd0,         1'b1, 32'd7,    32'd7,    3, 32'd7,    32'd7,    0, 1'b0};

    repeat (3) tick;
    check_reset_values("reset");
    aresetn = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Backpressure: 20 draws into an 8-deep FIFO with the sink stalled
    e0 = en_n; r0 = rx_n;
    out_ready = 1'b0;
    send(20, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, acc);
    repeat (40) tick;
    chk("bp enables_stalled", en_n - e0, 8);
    chk("bp out_valid_held", out_valid, 1'b1);
    chk("bp no_words", rx_n - r0, 0);
    out_ready = 1'b1;
    wait_done("bp", dcyc);
    tick;
    chk("bp enables", en_n - e0, 20);
    chk("bp words", rx_n - r0, 20);
    check_words("bp", r0, 20, 1'b0, 32'd0, 32'd0);

    // Abort during the 4th ISSUE of a 10-word burst, sink stalled
    e0 = en_n; r0 = rx_n; d0 = done_n; a0 = abort_n; p0 = preset_n;
    out_ready = 1'b0;
    send(10, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, acc);
    n = 0;
    while (en_n - e0 < 3 && n < 100) begin tick; n++; end
    tick;
    cmd_abort = 1'b1;
    tick;
    cmd_abort = 1'b0;
    chk("abort ready_next", cmd_ready, 1'b1);
    chk("abort out_valid_flushed", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick;
    chk("abort enables", en_n - e0, 3);
    chk("abort aborted_pulses", abort_n - a0, 1);
    chk("abort reset_pulses", preset_n - p0, 1);
    chk("abort no_done", done_n - d0, 0);
    chk("abort no_words", rx_n - r0, 0);
    r_state = 32'd42; r_low = 32'd0; r_high = 32'd100;

    // Asynchronous reset mid-burst with err_novalid already set
    e0 = en_n;
    drop_at = e0 + 1;
    send(10, 1'b1, 32'hA5A5A5A5, 1'b0, 32'd0, 32'd0, acc);
    n = 0;
    while (en_n - e0 < 3 && n < 100) begin tick; n++; end
    chk("rst err_before", err_novalid, 1'b1);
    chk("rst busy_before", busy, 1'b1);
    chk("rst seed_before", prng_new_seed, 32'hA5A5A5A5);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_values("rst midburst");
    repeat (2) tick;
    aresetn = 1'b1;
    tick;
    r_state = 32'd42; r_low = 32'd0; r_high = 32'd100;
    run_vec(vt[0], "recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
